// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: counters, sync/blank, look-ahead pixel requests and registered 5/6/5 output.
// Optional build macro VGA_TEST_PATTERN_EN replaces pix_* with an internal 8-bar colour generator.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int LOOKAHEAD = 2,
    parameter int R_W       = 5,
    parameter int G_W       = 6,
    parameter int B_W       = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    output logic [11:0]    req_x,
    output logic [10:0]    req_y,
    output logic           req_valid,
    output logic           line_start,
    output logic           frame_start,
    input  logic [R_W-1:0] pix_r,
    input  logic [G_W-1:0] pix_g,
    input  logic [B_W-1:0] pix_b,
    output logic [R_W-1:0] vga_r,
    output logic [G_W-1:0] vga_g,
    output logic [B_W-1:0] vga_b,
    output logic           vga_hs,
    output logic           vga_vs
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_VIS    = 12'(H_VISIBLE);
    localparam logic [11:0] HS_START = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] HS_END   = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;

    logic h_vis, v_vis, de, hs_raw, vs_raw;

    logic [LOOKAHEAD-1:0] de_sr_q, de_sr_d;
    logic [LOOKAHEAD-1:0] hs_sr_q, hs_sr_d;
    logic [LOOKAHEAD-1:0] vs_sr_q, vs_sr_d;

    logic [R_W-1:0] src_r;
    logic [G_W-1:0] src_g;
    logic [B_W-1:0] src_b;

    logic [R_W-1:0] vga_r_q, vga_r_d;
    logic [G_W-1:0] vga_g_q, vga_g_d;
    logic [B_W-1:0] vga_b_q, vga_b_d;
    logic           vga_hs_q, vga_hs_d;
    logic           vga_vs_q, vga_vs_d;

    // Request side is purely combinational from the counters; enable gates the qualifiers only.
    assign h_vis  = (h_cnt_q < H_VIS);
    assign v_vis  = (v_cnt_q < V_VIS);
    assign de     = enable && h_vis && v_vis;
    assign hs_raw = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    assign vs_raw = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);

    assign req_x       = h_cnt_q;
    assign req_y       = v_cnt_q;
    assign req_valid   = de;
    assign line_start  = enable && (h_cnt_q == 12'd0) && v_vis;
    assign frame_start = enable && (h_cnt_q == 12'd0) && (v_cnt_q == 11'd0);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!enable) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
        end else begin
            h_cnt_d = h_cnt_q + 12'd1;
        end
    end

    // Stage LOOKAHEAD-1 lines up with the pix_* returned for the same coordinate.
    always_comb begin
        de_sr_d = '0;
        hs_sr_d = '0;
        vs_sr_d = '0;
        if (enable) begin
            de_sr_d[0] = de;
            hs_sr_d[0] = hs_raw;
            vs_sr_d[0] = vs_raw;
            for (int i = 1; i < LOOKAHEAD; i++) begin
                de_sr_d[i] = de_sr_q[i-1];
                hs_sr_d[i] = hs_sr_q[i-1];
                vs_sr_d[i] = vs_sr_q[i-1];
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_VISIBLE / 8;

    logic [11:0] x_sr_q [LOOKAHEAD];
    logic [11:0] x_sr_d [LOOKAHEAD];
    logic [2:0]  bar;

    always_comb begin
        for (int i = 0; i < LOOKAHEAD; i++) begin
            x_sr_d[i] = '0;
        end
        if (enable) begin
            x_sr_d[0] = h_cnt_q;
            for (int i = 1; i < LOOKAHEAD; i++) begin
                x_sr_d[i] = x_sr_q[i-1];
            end
        end
    end

    // Bar index by threshold count avoids a divider.
    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x_sr_q[LOOKAHEAD-1] >= 12'(k * BAR_W)) begin
                bar = bar + 3'd1;
            end
        end
    end

    // Bar order white, yellow, cyan, green, magenta, red, blue, black.
    assign src_r = {R_W{~bar[1]}};
    assign src_g = {G_W{~bar[2]}};
    assign src_b = {B_W{~bar[0]}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LOOKAHEAD; i++) begin
                x_sr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LOOKAHEAD; i++) begin
                x_sr_q[i] <= x_sr_d[i];
            end
        end
    end
`else
    assign src_r = pix_r;
    assign src_g = pix_g;
    assign src_b = pix_b;
`endif

    always_comb begin
        vga_r_d  = '0;
        vga_g_d  = '0;
        vga_b_d  = '0;
        vga_hs_d = ~HS_POL;
        vga_vs_d = ~VS_POL;
        if (enable) begin
            if (de_sr_q[LOOKAHEAD-1]) begin
                vga_r_d = src_r;
                vga_g_d = src_g;
                vga_b_d = src_b;
            end
            if (hs_sr_q[LOOKAHEAD-1]) begin
                vga_hs_d = HS_POL;
            end
            if (vs_sr_q[LOOKAHEAD-1]) begin
                vga_vs_d = VS_POL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            de_sr_q  <= '0;
            hs_sr_q  <= '0;
            vs_sr_q  <= '0;
            vga_r_q  <= '0;
            vga_g_q  <= '0;
            vga_b_q  <= '0;
            vga_hs_q <= ~HS_POL;
            vga_vs_q <= ~VS_POL;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            de_sr_q  <= de_sr_d;
            hs_sr_q  <= hs_sr_d;
            vs_sr_q  <= vs_sr_d;
            vga_r_q  <= vga_r_d;
            vga_g_q  <= vga_g_d;
            vga_b_q  <= vga_b_d;
            vga_hs_q <= vga_hs_d;
            vga_vs_q <= vga_vs_d;
        end
    end

    assign vga_r  = vga_r_q;
    assign vga_g  = vga_g_q;
    assign vga_b  = vga_b_q;
    assign vga_hs = vga_hs_q;
    assign vga_vs = vga_vs_q;

endmodule
